// File: rtl/serial_cmd_manager.sv
// serial_cmd_manager
//   Framed command engine between an RS232 byte receiver/transmitter pair and
//   a byte-wide memory controller.
//   Frame: CMD, ADDR (ADDR_W/8 bytes, MSB first), LEN, payload (write only), CHK.
//   CHK is the XOR of all preceding frame bytes. Transfer count is LEN+1.
//   Write payload is buffered and checked before any memory access starts.
// Ports:
//   clk_50mhz_i, rst_i (sync, active-high)
//   rx_data_i/rx_valid_i            received byte stream
//   tx_data_o/tx_trg_o/tx_done_i    transmit handshake
//   mem_addr_o/mem_wdata_o/mem_we_o/mem_trg_o/mem_rdata_i/mem_done_i
//                                   memory access handshake
//   busy_o                          high whenever not idle
//   err_cnt_o                       saturating count of rejected frames
module serial_cmd_manager #(
  parameter int ADDR_W    = 16,
  parameter int BUF_DEPTH = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic              clk_50mhz_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_trg_o,
  input  logic              tx_done_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_trg_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_done_i,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o
);

  localparam int NB    = ADDR_W / 8;
  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_P   = 8'h50;
  localparam logic [7:0] ST_ACK  = 8'h06;
  localparam logic [7:0] ST_NAK  = 8'h15;
  localparam logic [7:0] ST_REJ  = 8'h18;
  localparam logic [7:0] ST_TMO  = 8'h1B;

  typedef enum logic [3:0] {
    S_IDLE, S_RX_ADDR, S_RX_LEN, S_RX_PAY, S_RX_CHK,
    S_EXEC_WR, S_EXEC_RD, S_TX_STAT, S_TX_RD, S_TX_CHK, S_TX_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         xor_q, xor_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         err_q, err_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_trg_q, tx_trg_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_trg_q, mem_trg_d;
  logic [7:0]         pay_q [BUF_DEPTH];
  logic               pay_we;
  logic [IDX_W-1:0]   nxt_idx;
  logic               oversize, unknown, last;
  logic [7:0]         err_inc;

  // Payload longer than the buffer is still consumed so the frame stays in sync.
  assign oversize = ({1'b0, len_q} >= 9'(BUF_DEPTH));
  assign unknown  = (cmd_q != CMD_W) && (cmd_q != CMD_R) && (cmd_q != CMD_P);
  assign last     = (cnt_q == len_q);
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign nxt_idx  = cnt_q[IDX_W-1:0] + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    xor_d       = xor_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    tx_data_d   = tx_data_q;
    tx_trg_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_trg_d   = 1'b0;
    pay_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_valid_i) begin
          cmd_d   = rx_data_i;
          xor_d   = rx_data_i;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = S_RX_ADDR;
        end
      end
      S_RX_ADDR, S_RX_LEN, S_RX_PAY, S_RX_CHK: begin
        if (!rx_valid_i) begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_MAX) begin
            tmo_d     = '0;
            tx_data_d = ST_TMO;
            tx_trg_d  = 1'b1;
            err_d     = err_inc;
            state_d   = S_TX_STAT;
          end
        end else begin
          tmo_d = '0;
          xor_d = xor_q ^ rx_data_i;
          case (state_q)
            S_RX_ADDR: begin
              addr_d = (addr_q << 8) | ADDR_W'(rx_data_i);
              if (cnt_q == 8'(NB - 1)) begin
                cnt_d   = '0;
                state_d = S_RX_LEN;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
            S_RX_LEN: begin
              len_d   = rx_data_i;
              cnt_d   = '0;
              state_d = (cmd_q == CMD_W) ? S_RX_PAY : S_RX_CHK;
            end
            S_RX_PAY: begin
              pay_we = !oversize;
              if (last) state_d = S_RX_CHK;
              else      cnt_d   = cnt_q + 8'd1;
            end
            default: begin  // S_RX_CHK
              cnt_d = '0;
              xor_d = '0;   // reused as the read-data checksum
              if (rx_data_i != xor_q || unknown || (cmd_q == CMD_W && oversize)) begin
                tx_data_d = (rx_data_i != xor_q) ? ST_NAK : ST_REJ;
                tx_trg_d  = 1'b1;
                err_d     = err_inc;
                state_d   = S_TX_STAT;
              end else if (cmd_q == CMD_W) begin
                mem_addr_d  = addr_q;
                mem_we_d    = 1'b1;
                mem_wdata_d = pay_q[0];
                mem_trg_d   = 1'b1;
                state_d     = S_EXEC_WR;
              end else begin
                tx_data_d = ST_ACK;
                tx_trg_d  = 1'b1;
                state_d   = S_TX_STAT;
              end
            end
          endcase
        end
      end
      S_EXEC_WR: begin
        if (mem_done_i) begin
          if (last) begin
            tx_data_d = ST_ACK;
            tx_trg_d  = 1'b1;
            state_d   = S_TX_STAT;
          end else begin
            cnt_d       = cnt_q + 8'd1;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = pay_q[nxt_idx];
            mem_trg_d   = 1'b1;
          end
        end
      end
      S_TX_STAT: begin
        if (tx_done_i) begin
          // An acknowledged read continues into the data phase.
          if (cmd_q == CMD_R && tx_data_q == ST_ACK) begin
            mem_addr_d = addr_q;
            mem_we_d   = 1'b0;
            mem_trg_d  = 1'b1;
            state_d    = S_EXEC_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_EXEC_RD: begin
        if (mem_done_i) begin
          tx_data_d = mem_rdata_i;
          tx_trg_d  = 1'b1;
          xor_d     = xor_q ^ mem_rdata_i;
          state_d   = S_TX_RD;
        end
      end
      S_TX_RD: begin
        if (tx_done_i) begin
          if (last) begin
            state_d = S_TX_CHK;
          end else begin
            cnt_d      = cnt_q + 8'd1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            mem_trg_d  = 1'b1;
            state_d    = S_EXEC_RD;
          end
        end
      end
      S_TX_CHK: begin
        tx_data_d = xor_q;
        tx_trg_d  = 1'b1;
        state_d   = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      xor_q       <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      tx_data_q   <= '0;
      tx_trg_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_trg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      tx_data_q   <= tx_data_d;
      tx_trg_q    <= tx_trg_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_trg_q   <= mem_trg_d;
    end
  end

  // Payload storage carries no reset; it is always written before it is read.
  always_ff @(posedge clk_50mhz_i) begin
    if (pay_we) pay_q[cnt_q[IDX_W-1:0]] <= rx_data_i;
  end

  assign tx_data_o   = tx_data_q;
  assign tx_trg_o    = tx_trg_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_trg_o   = mem_trg_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_serial_cmd_manager.sv
module tb_serial_cmd_manager;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_trg;
  logic        tx_done = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_trg;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_done = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  serial_cmd_manager #(.ADDR_W(16), .BUF_DEPTH(16), .TIMEOUT(TMO)) dut (
    .clk_50mhz_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_trg_o(tx_trg), .tx_done_i(tx_done),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_trg_o(mem_trg), .mem_rdata_i(mem_rdata), .mem_done_i(mem_done),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  tx_q[$];
  logic [15:0] acc_q[$];
  int          mem_cnt = 0, tx_cnt = 0, mem_cd = 0, tx_cd = 0, mem_lat = 3;
  logic [15:0] m_addr = 16'h0;
  logic        m_we = 1'b0;

  // Memory and transmitter models respond 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    mem_done = 1'b0;
    tx_done  = 1'b0;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        mem_done = 1'b1;
        if (!m_we) mem_rdata = mem[m_addr];
      end
    end
    if (mem_trg) begin
      mem_cnt++;
      acc_q.push_back(mem_addr);
      m_addr = mem_addr;
      m_we   = mem_we;
      if (mem_we) mem[mem_addr] = mem_wdata;
      mem_cd = mem_lat;
    end
    if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) tx_done = 1'b1;
    end
    if (tx_trg) begin
      tx_cnt++;
      tx_q.push_back(tx_data);
      tx_cd = 4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  // Sends n body bytes (first byte in the most significant position) plus CHK.
  task automatic send_frame(input logic [191:0] body, input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int j = 0; j < n; j++) begin
      b = body[8*(n-1-j) +: 8];
      x = x ^ b;
      send(b);
    end
    send(x ^ {7'b0, bad});
  endtask

  typedef struct {
    string        name;
    logic [191:0] body;
    int           nbody;
    bit           bad;
    logic [63:0]  exp_tx;
    int           ntx;
    int           nmem;
    logic [15:0]  first;
    logic [7:0]   err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [7:0]  x;
    logic [7:0]  e;
    int          cnt;
    int          tx0, m0;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hA5;

    vecs[0]  = '{"ping",        192'h50000000,             4,  1'b0, 64'h06,       1, 0,  16'h0000, 8'd0};
    vecs[1]  = '{"wr_burst",    192'h57123402AABBCC,       7,  1'b0, 64'h06,       1, 3,  16'h1234, 8'd0};
    vecs[2]  = '{"rd_wrap",     192'h52FFFF01,             4,  1'b0, 64'h065AA5FF, 4, 2,  16'hFFFF, 8'd0};
    vecs[3]  = '{"wr_badchk",   192'h5700100077,           5,  1'b1, 64'h15,       1, 0,  16'h0000, 8'd1};
    vecs[4]  = '{"wr_oversize", {8'h57, 8'h00, 8'h20, 8'h10, {17{8'h5A}}}, 21, 1'b0, 64'h18, 1, 0, 16'h0000, 8'd2};
    vecs[5]  = '{"unknown_cmd", 192'h41000000,             4,  1'b0, 64'h18,       1, 0,  16'h0000, 8'd3};
    vecs[6]  = '{"rd_single",   192'h52123400,             4,  1'b0, 64'h06AAAA,   3, 1,  16'h1234, 8'd3};
    vecs[7]  = '{"ping_badchk", 192'h50000000,             4,  1'b1, 64'h15,       1, 0,  16'h0000, 8'd4};
    vecs[8]  = '{"wr_len0",     192'h570005003C,           5,  1'b0, 64'h06,       1, 1,  16'h0005, 8'd4};
    vecs[9]  = '{"wr_full_buf", {8'h57, 8'h01, 8'h00, 8'h0F, 128'h00112233445566778899AABBCCDDEEFF}, 20, 1'b0, 64'h06, 1, 16, 16'h0100, 8'd4};
    vecs[10] = '{"rd_buf_tail", 192'h52010E01,             4,  1'b0, 64'h06EEFF11, 4, 2,  16'h010E, 8'd4};
    vecs[11] = '{"rd_len0",     192'h52000500,             4,  1'b0, 64'h063C3C,   3, 1,  16'h0005, 8'd4};
    vecs[12] = '{"unk_badchk",  192'h41000000,             4,  1'b1, 64'h15,       1, 0,  16'h0000, 8'd5};

    // Reset values
    repeat (3) step();
    check("rst_tx_data",   {24'b0, tx_data}, 32'h0);
    check("rst_tx_trg",    {31'b0, tx_trg}, 32'h0);
    check("rst_mem_addr",  {16'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
    check("rst_mem_we",    {31'b0, mem_we}, 32'h0);
    check("rst_mem_trg",   {31'b0, mem_trg}, 32'h0);
    check("rst_busy",      {31'b0, busy}, 32'h0);
    check("rst_err_cnt",   {24'b0, err_cnt}, 32'h0);
    rst = 1'b0;
    step();

    // Table-driven frames
    for (int i = 0; i < 13; i++) begin
      tx_q.delete();
      acc_q.delete();
      mem_cnt = 0;
      send_frame(vecs[i].body, vecs[i].nbody, vecs[i].bad);
      wait_idle(3000);
      check({vecs[i].name, "_ntx"}, tx_q.size(), vecs[i].ntx);
      for (int k = 0; k < vecs[i].ntx; k++) begin
        e = vecs[i].exp_tx[8*(vecs[i].ntx-1-k) +: 8];
        if (k < tx_q.size()) check({vecs[i].name, "_tx"}, {24'b0, tx_q[k]}, {24'b0, e});
      end
      check({vecs[i].name, "_nmem"}, mem_cnt, vecs[i].nmem);
      if (vecs[i].nmem > 0 && acc_q.size() > 0) begin
        check({vecs[i].name, "_addr_first"}, {16'b0, acc_q[0]}, {16'b0, vecs[i].first});
        check({vecs[i].name, "_addr_last"}, {16'b0, acc_q[acc_q.size()-1]},
              {16'b0, 16'(vecs[i].first + 16'(vecs[i].nmem - 1))});
      end
      check({vecs[i].name, "_err"}, {24'b0, err_cnt}, {24'b0, vecs[i].err});
    end
    check("wr_burst_m1234", {24'b0, mem[16'h1234]}, 32'hAA);
    check("wr_burst_m1235", {24'b0, mem[16'h1235]}, 32'hBB);
    check("wr_burst_m1236", {24'b0, mem[16'h1236]}, 32'hCC);
    check("wr_badchk_m1000", {24'b0, mem[16'h1000]}, 32'h00);

    // Write start latency, nothing before CHK, RX dropped during execution
    mem_cnt = 0;
    x = 8'h00;
    foreach (vecs[0].exp_tx[i]) ;
    x = 8'h57 ^ 8'h20 ^ 8'h00 ^ 8'h01 ^ 8'h11 ^ 8'h22;
    send(8'h57); send(8'h20); send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    check("wr_no_early_trg", mem_cnt, 0);
    send(x);
    check("wr_lat_trg",   {31'b0, mem_trg}, 32'h1);
    check("wr_lat_addr",  {16'b0, mem_addr}, 32'h2000);
    check("wr_lat_we",    {31'b0, mem_we}, 32'h1);
    check("wr_lat_wdata", {24'b0, mem_wdata}, 32'h11);
    step();
    send(8'h50);
    wait_idle(500);
    check("wr2_m2000", {24'b0, mem[16'h2000]}, 32'h11);
    check("wr2_m2001", {24'b0, mem[16'h2001]}, 32'h22);
    repeat (5) step();
    check("drop_rx_busy", {31'b0, busy}, 32'h0);
    check("drop_rx_err",  {24'b0, err_cnt}, 32'd5);

    // Read start latency, then reset while a read is outstanding
    mem_lat = 12;
    send(8'h52); send(8'h00); send(8'h05); send(8'h00);
    send(8'h52 ^ 8'h05);
    check("rd_lat_trg",  {31'b0, tx_trg}, 32'h1);
    check("rd_lat_data", {24'b0, tx_data}, 32'h06);
    cnt = 0;
    while (!mem_trg && cnt < 100) begin
      step();
      cnt++;
    end
    check("rd_mem_trg_seen", {31'b0, mem_trg}, 32'h1);
    step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_tx_trg",   {31'b0, tx_trg}, 32'h0);
    check("mid_rst_mem_trg",  {31'b0, mem_trg}, 32'h0);
    check("mid_rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    check("mid_rst_mem_we",   {31'b0, mem_we}, 32'h0);
    check("mid_rst_tx_data",  {24'b0, tx_data}, 32'h0);
    check("mid_rst_busy",     {31'b0, busy}, 32'h0);
    check("mid_rst_err",      {24'b0, err_cnt}, 32'h0);
    rst = 1'b0;
    tx0 = tx_cnt;
    m0  = mem_cnt;
    repeat (25) step();
    check("late_done_no_tx",  tx_cnt, tx0);
    check("late_done_no_mem", mem_cnt, m0);
    check("late_done_busy",   {31'b0, busy}, 32'h0);
    mem_lat = 3;

    // Gap of exactly TIMEOUT idle cycles is tolerated
    tx_q.delete();
    send(8'h50);
    repeat (TMO) step();
    send(8'h00); send(8'h00); send(8'h00); send(8'h50);
    wait_idle(500);
    check("gap_ok_ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) check("gap_ok_tx", {24'b0, tx_q[0]}, 32'h06);
    check("gap_ok_err", {24'b0, err_cnt}, 32'd0);

    // Gap of TIMEOUT+1 idle cycles aborts with 0x1B
    tx_q.delete();
    send(8'h57); send(8'h12);
    cnt = 0;
    while (!tx_trg && cnt < TMO + 10) begin
      step();
      cnt++;
    end
    check("tmo_cycles", cnt, TMO + 1);
    check("tmo_tx_data", {24'b0, tx_data}, 32'h1B);
    wait_idle(500);
    check("tmo_err", {24'b0, err_cnt}, 32'd1);
    tx_q.delete();
    send_frame(192'h50000000, 4, 1'b0);
    wait_idle(500);
    check("tmo_ping_ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) check("tmo_ping_tx", {24'b0, tx_q[0]}, 32'h06);
    check("tmo_ping_err", {24'b0, err_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
